// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman array: score width, score bias,
// collector FSM encoding and the nucleotide codes used by the PEs.
package sw_pkg;

  localparam int SW_SCORE_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    NT_A = 2'd0,
    NT_C = 2'd1,
    NT_G = 2'd2,
    NT_T = 2'd3
  } nt_e;

  // PE scores are offset by half the code space so that they stay unsigned.
  function automatic int sw_zero(input int score_width);
    return 1 << (score_width - 1);
  endfunction

endpackage

// File: rtl/sw_result_fifo.sv
// Generic synchronous FIFO. A push into a full FIFO is accepted when a pop
// happens in the same cycle; a pop on an empty FIFO is ignored.
module sw_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == DEPTH_C);
  assign count    = cnt_q;
  assign pop_data = mem_q[rd_q];

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    if (do_push) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sw_score_collector.sv
// Collects the final score of each target sequence from the last PE, removes
// the bias, tags length/ID/hit and queues the result for the host side.
module sw_score_collector
  import sw_pkg::*;
#(
  parameter int SCORE_WIDTH = SW_SCORE_WIDTH,
  parameter int ID_WIDTH    = 8,
  parameter int LEN_WIDTH   = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en_in,
  input  logic                         vld_in,
  input  logic [SCORE_WIDTH-1:0]       high_in,
  input  logic [SCORE_WIDTH-2:0]       threshold,
  input  logic                         clear,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [SCORE_WIDTH-2:0]       res_score,
  output logic                         res_hit,
  output logic [LEN_WIDTH-1:0]         res_len,
  output logic [ID_WIDTH-1:0]          res_id,
  output logic [7:0]                   drop_cnt,
  output logic                         overflow,
  output logic                         proto_err,
  output logic [1:0]                   state_dbg,
  output logic [$clog2(FIFO_DEPTH):0]  fill_dbg
);

  localparam logic [SCORE_WIDTH-1:0] ZERO = SCORE_WIDTH'(sw_zero(SCORE_WIDTH));
  localparam int RW = (SCORE_WIDTH - 1) + 1 + LEN_WIDTH + ID_WIDTH;

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [ID_WIDTH-1:0]   next_id_q, next_id_d;
  logic [7:0]            drop_cnt_q, drop_cnt_d;
  logic                  overflow_q, overflow_d;
  logic                  proto_err_q, proto_err_d;

  logic                  capture, proto_set, drop, underflow, hit_w;
  logic [SCORE_WIDTH-2:0] score_w;
  logic [RW-1:0]         push_data, head_data;
  logic                  fifo_full, fifo_empty;

  // Result handshake: res_valid is the registered FIFO non-empty flag; the head
  // is popped on any cycle with res_valid && res_ready and held stable otherwise.
  sw_result_fifo #(.WIDTH(RW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (capture),
    .push_data (push_data),
    .pop       (res_ready),
    .pop_data  (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fill_dbg)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    capture   = 1'b0;
    proto_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (vld_in) proto_set = 1'b1;
        if (en_in) begin
          state_d = RUN;
          len_d   = LEN_WIDTH'(1);
        end
      end
      RUN: begin
        if (vld_in) proto_set = 1'b1;
        if (en_in) begin
          if (len_q != '1) len_d = len_q + 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (vld_in) begin
          capture = 1'b1;
          state_d = IDLE;
        end else if (en_in) begin
          // A new target started before the score arrived: drop the old one.
          proto_set = 1'b1;
          state_d   = RUN;
          len_d     = LEN_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // The bias is exactly the MSB, so unbiasing is dropping that bit.
    underflow = (high_in < ZERO);
    score_w   = underflow ? '0 : high_in[SCORE_WIDTH-2:0];
    hit_w     = (score_w >= threshold);
    if (capture && underflow) proto_set = 1'b1;
    push_data = {score_w, hit_w, len_q, next_id_q};

    drop        = capture && fifo_full && !res_ready;
    next_id_d   = capture ? next_id_q + 1'b1 : next_id_q;
    drop_cnt_d  = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 1'b1 : drop_cnt_q;
    overflow_d  = overflow_q | drop;
    proto_err_d = proto_err_q | proto_set;
    if (clear) begin
      next_id_d   = '0;
      drop_cnt_d  = '0;
      overflow_d  = 1'b0;
      proto_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      next_id_q   <= '0;
      drop_cnt_q  <= '0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      next_id_q   <= next_id_d;
      drop_cnt_q  <= drop_cnt_d;
      overflow_q  <= overflow_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign res_valid = !fifo_empty;
  assign {res_score, res_hit, res_len, res_id} = head_data;
  assign drop_cnt  = drop_cnt_q;
  assign overflow  = overflow_q;
  assign proto_err = proto_err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sw_score_collector.sv
// Directed bench for sw_score_collector: stimulus pushes expected results into
// a queue, a negedge monitor pops and compares on every accepted result.
module tb_sw_score_collector;

  localparam int SW = 12;
  localparam int IW = 8;
  localparam int LW = 16;
  localparam int DW = 4;
  localparam int RW = (SW - 1) + 1 + LW + IW;

  logic          clk, rst, en_in, vld_in, clear, res_ready;
  logic [SW-1:0] high_in;
  logic [SW-2:0] threshold;
  logic          res_valid, res_hit, overflow, proto_err;
  logic [SW-2:0] res_score;
  logic [LW-1:0] res_len;
  logic [IW-1:0] res_id;
  logic [7:0]    drop_cnt;
  logic [1:0]    state_dbg;
  logic [2:0]    fill_dbg;

  logic [RW-1:0] exp_q[$];
  int            tests = 0;
  int            fails = 0;

  sw_score_collector #(.SCORE_WIDTH(SW), .ID_WIDTH(IW), .LEN_WIDTH(LW), .FIFO_DEPTH(DW)) dut (
    .clk(clk), .rst(rst), .en_in(en_in), .vld_in(vld_in), .high_in(high_in),
    .threshold(threshold), .clear(clear), .res_valid(res_valid), .res_ready(res_ready),
    .res_score(res_score), .res_hit(res_hit), .res_len(res_len), .res_id(res_id),
    .drop_cnt(drop_cnt), .overflow(overflow), .proto_err(proto_err),
    .state_dbg(state_dbg), .fill_dbg(fill_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic logic [RW-1:0] pack(input logic [SW-2:0] s, input logic h,
                                         input logic [LW-1:0] l, input logic [IW-1:0] id);
    return {s, h, l, id};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_seq(input int len, input logic [SW-1:0] high, input bit exp_push,
                          input logic [RW-1:0] exp_val, input bit pop_same);
    en_in = 1'b1;
    repeat (len) cyc();
    en_in = 1'b0;
    cyc();
    vld_in  = 1'b1;
    high_in = high;
    if (exp_push) exp_q.push_back(exp_val);
    if (pop_same) res_ready = 1'b1;
    cyc();
    vld_in = 1'b0;
    if (pop_same) res_ready = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || res_valid) && n < 100) begin
      cyc();
      n++;
    end
    check("drain", 64'(n < 100), 64'(1));
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got %0h required no result",
                 {res_score, res_hit, res_len, res_id});
      end else begin
        logic [RW-1:0] e;
        e = exp_q.pop_front();
        check("result", 64'({res_score, res_hit, res_len, res_id}), 64'(e));
      end
    end
  end

  initial begin
    rst = 1'b0; en_in = 1'b0; vld_in = 1'b0; clear = 1'b0; res_ready = 1'b0;
    high_in = '0; threshold = 11'd30;
    #1 rst = 1'b1;
    #10;
    check("rst_valid", 64'(res_valid), 64'(0));
    check("rst_state", 64'(state_dbg), 64'(0));
    check("rst_flags", 64'({drop_cnt, overflow, proto_err}), 64'(0));
    check("rst_head", 64'({res_score, res_hit, res_len, res_id}), 64'(0));
    #11 rst = 1'b0;
    cyc();

    // 1: single sequence, length 10, score 37 above threshold 30
    res_ready = 1'b1;
    send_seq(10, 12'd2085, 1'b1, pack(11'd37, 1'b1, 16'd10, 8'd0), 1'b0);
    wait_drain();
    check("t1_state", 64'(state_dbg), 64'(0));
    check("t1_proto", 64'(proto_err), 64'(0));

    // 2: fill the FIFO with backpressure, fifth result is dropped
    pulse_clear();
    res_ready = 1'b0;
    send_seq(3, 12'd2053, 1'b1, pack(11'd5,   1'b0, 16'd3, 8'd0), 1'b0);
    send_seq(5, 12'd2148, 1'b1, pack(11'd100, 1'b1, 16'd5, 8'd1), 1'b0);
    send_seq(1, 12'd2078, 1'b1, pack(11'd30,  1'b1, 16'd1, 8'd2), 1'b0);
    send_seq(7, 12'd2077, 1'b1, pack(11'd29,  1'b0, 16'd7, 8'd3), 1'b0);
    check("t2_fill", 64'(fill_dbg), 64'(4));
    check("t2_no_drop_yet", 64'({drop_cnt, overflow}), 64'(0));
    send_seq(2, 12'd2049, 1'b0, '0, 1'b0);
    check("t2_drop_cnt", 64'(drop_cnt), 64'(1));
    check("t2_overflow", 64'(overflow), 64'(1));
    check("t2_valid", 64'(res_valid), 64'(1));

    // 3: push while full with a pop in the same cycle; dropped ID 4 leaves a gap
    send_seq(2, 12'd2055, 1'b1, pack(11'd7, 1'b0, 16'd2, 8'd5), 1'b1);
    check("t3_drop_cnt", 64'(drop_cnt), 64'(1));
    check("t3_fill", 64'(fill_dbg), 64'(4));
    res_ready = 1'b1;
    wait_drain();
    check("t3_proto", 64'(proto_err), 64'(0));

    // 4: biased score underflow, stray vld in IDLE, clear
    send_seq(2, 12'd2000, 1'b1, pack(11'd0, 1'b0, 16'd2, 8'd6), 1'b0);
    check("t4_underflow_proto", 64'(proto_err), 64'(1));
    wait_drain();
    pulse_clear();
    check("t4_clear_proto", 64'(proto_err), 64'(0));
    check("t4_clear_drop", 64'({drop_cnt, overflow}), 64'(0));
    vld_in = 1'b1;
    cyc();
    vld_in = 1'b0;
    check("t4_stray_proto", 64'(proto_err), 64'(1));
    cyc();
    check("t4_stray_no_push", 64'(res_valid), 64'(0));
    pulse_clear();
    check("t4_clear2", 64'({drop_cnt, overflow, proto_err}), 64'(0));

    // 5: restart in WAIT without vld, then a clean 4-base sequence
    en_in = 1'b1;
    repeat (3) cyc();
    en_in = 1'b0;
    cyc();
    cyc();
    check("t5_wait", 64'(state_dbg), 64'(2));
    send_seq(4, 12'd2058, 1'b1, pack(11'd10, 1'b0, 16'd4, 8'd0), 1'b0);
    check("t5_proto", 64'(proto_err), 64'(1));
    wait_drain();

    // 6: async reset mid-RUN with two entries queued
    res_ready = 1'b0;
    send_seq(2, 12'd2060, 1'b1, '0, 1'b0);
    send_seq(3, 12'd2061, 1'b1, '0, 1'b0);
    en_in = 1'b1;
    cyc();
    cyc();
    check("t6_run", 64'(state_dbg), 64'(1));
    check("t6_fill", 64'(fill_dbg), 64'(2));
    #3 rst = 1'b1;
    #1;
    check("t6_rst_valid", 64'(res_valid), 64'(0));
    check("t6_rst_state", 64'(state_dbg), 64'(0));
    check("t6_rst_fill", 64'(fill_dbg), 64'(0));
    exp_q.delete();
    en_in = 1'b0;
    #2 rst = 1'b0;
    cyc();
    res_ready = 1'b1;
    send_seq(3, 12'd2098, 1'b1, pack(11'd50, 1'b1, 16'd3, 8'd0), 1'b0);
    wait_drain();
    check("t6_flags", 64'({drop_cnt, overflow, proto_err}), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
